spi_cmd_seq: RTL and testbench
==============================

Name: spi_cmd_seq

Overview:
Command sequencer sitting directly upstream of the DSO's SPI master. It accepts single-word write or read requests from the command processor, drives the master's wrt/data_out strobe, and tracks the master's done handshake. Read requests are issued as two SPI transactions: the command word, then a dummy word that clocks out the slave response, which is returned as rsp. It enforces a minimum inter-frame gap and a per-transaction timeout.

Parameters:
GAP_CYC, 8, idle clk cycles inserted between the two frames of a read and after every completed request (1..255)
TIMEOUT_CYC, 2048, maximum clk cycles from wrt to done rising before abort (must exceed one SPI frame, about 600 clk)
DUMMY_WORD, 16'h0000, data_out value sent on the second frame of a read

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
cmd_vld  input  1  request strobe; sampled only when busy=0
cmd_rd  input  1  1 = read (two frames), 0 = write (one frame); sampled with cmd_vld
cmd  input  16  command/data word for first frame
busy  output  1  high from cycle after accepted cmd_vld until return to IDLE
rsp_vld  output  1  one-cycle pulse: request complete (read or write)
rsp  output  16  read response; held until next read completes
err  output  1  sticky timeout flag; cleared by next accepted cmd_vld
wrt  output  1  one-cycle strobe to SPI master
data_out  output  16  word to SPI master; valid on wrt cycle and held stable until the frame completes
done  input  1  SPI master done; high while master idle, low during frame
data_in  input  16  SPI master shift register; valid when done rises

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, rsp_vld=0, rsp=16'h0000, err=0, wrt=0, data_out=16'h0000; counters cleared. Reset mid-frame abandons the request, with no rsp_vld.
- States: IDLE, LAUNCH, WAIT_LOW, WAIT_HIGH, GAP, DONE.
- IDLE: cmd_vld=1 captures cmd, cmd_rd; clears err; sets frame index=0; goes to LAUNCH. cmd_vld while busy=1 is ignored, with no queueing.
- LAUNCH: wrt=1 for exactly one cycle. data_out = cmd (frame 0) or DUMMY_WORD (frame 1). Timeout counter reset. Next state is WAIT_LOW.
- WAIT_LOW: wait for done=0. The master's done is high while idle, so done is not treated as completion until it has been seen low. Next state is WAIT_HIGH when done=0.
- WAIT_HIGH: done rising (done=1 after done=0) marks the frame complete. If the frame was frame 1 of a read, latch rsp <= data_in on that cycle. Next state is GAP.
- Timeout: the counter runs in WAIT_LOW and WAIT_HIGH. At count TIMEOUT_CYC-1 with no completion: set err=1, go to DONE with rsp unchanged, skipping remaining frames and the gap.
- GAP: count GAP_CYC cycles with wrt=0. Then, if read and frame index=0, set frame index=1 and go to LAUNCH. Otherwise go to DONE.
- DONE: rsp_vld=1 for one cycle; next state IDLE; busy deasserts the following cycle. A new cmd_vld is accepted in IDLE only, so minimum request spacing is 1 cycle after DONE.
- busy is registered: 1 in every state except IDLE.
- Write latency: wrt at cycle 1 after accept; rsp_vld = frame time + GAP_CYC + ~3 cycles.
- Read: two full frames plus two gaps. rsp reflects the second frame's data_in only.
- done rising and timeout expiring on the same cycle: completion wins, with no err.
- Counters saturate/wrap checks: the gap counter is 8-bit and the timeout counter is sized by $clog2(TIMEOUT_CYC). Neither counter wraps within a state.

Test Plan:
1. Write: cmd_vld with cmd_rd=0, cmd=16'hC0A5; master model drops done 1 cycle after wrt and raises it 540 cycles later -> single wrt with data_out=16'hC0A5, rsp_vld pulse 8+ cycles after done rises, rsp unchanged (16'h0000), err=0.
2. Read: cmd_rd=1, cmd=16'h8300; slave returns 16'h1234 on frame 2 -> two wrt strobes (data_out 16'h8300 then 16'h0000) separated by at least 8 idle cycles after the first done rise; rsp=16'h1234 at rsp_vld.
3. Busy rejection: second cmd_vld (16'hFFFF) during a read -> ignored, only two wrt strobes issued; a later cmd_vld after busy=0 is accepted.
4. Timeout: done held high (master never starts) -> err=1 and rsp_vld exactly TIMEOUT_CYC cycles after wrt; the next accepted command clears err.
5. Reset mid-read (rst_n low during WAIT_HIGH of frame 1) -> all outputs return to reset values immediately, no rsp_vld; a fresh write completes normally afterwards.
6. Simultaneous event: done rises on the final timeout cycle -> treated as success, err=0, read proceeds to frame 2.

Source files
------------

// File: rtl/spi_cmd_seq.sv
// Command sequencer in front of the SPI master: one frame per write, two frames per read
// (command + dummy), with an inter-frame gap and a per-frame timeout.
module spi_cmd_seq #(
   parameter int unsigned GAP_CYC     = 8,
   parameter int unsigned TIMEOUT_CYC = 2048,
   parameter logic [15:0] DUMMY_WORD  = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_vld,
   input  logic        cmd_rd,
   input  logic [15:0] cmd,
   output logic        busy,
   output logic        rsp_vld,
   output logic [15:0] rsp,
   output logic        err,
   output logic        wrt,
   output logic [15:0] data_out,
   input  logic        done,
   input  logic [15:0] data_in
);

   localparam int unsigned DW = 16;
   localparam int unsigned GW = 8;
   localparam int unsigned TW = $clog2(TIMEOUT_CYC);

   localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT_CYC - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_LAUNCH    = 3'd1;
   localparam logic [2:0] S_WAIT_LOW  = 3'd2;
   localparam logic [2:0] S_WAIT_HIGH = 3'd3;
   localparam logic [2:0] S_GAP       = 3'd4;
   localparam logic [2:0] S_DONE      = 3'd5;

   logic [2:0]    state, state_nxt;
   logic          is_rd, is_rd_nxt;
   logic          frm, frm_nxt;
   logic [TW-1:0] tcnt, tcnt_nxt;
   logic [GW-1:0] gcnt, gcnt_nxt;
   logic          busy_nxt, rsp_vld_nxt, err_nxt, wrt_nxt;
   logic [DW-1:0] rsp_nxt, data_out_nxt;

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         is_rd    <= 1'b0;
         frm      <= 1'b0;
         tcnt     <= '0;
         gcnt     <= '0;
         busy     <= 1'b0;
         rsp_vld  <= 1'b0;
         rsp      <= '0;
         err      <= 1'b0;
         wrt      <= 1'b0;
         data_out <= '0;
      end else begin
         state    <= state_nxt;
         is_rd    <= is_rd_nxt;
         frm      <= frm_nxt;
         tcnt     <= tcnt_nxt;
         gcnt     <= gcnt_nxt;
         busy     <= busy_nxt;
         rsp_vld  <= rsp_vld_nxt;
         rsp      <= rsp_nxt;
         err      <= err_nxt;
         wrt      <= wrt_nxt;
         data_out <= data_out_nxt;
      end
   end

   // Next state; registered outputs are computed one cycle ahead so they line up with the state
   always_comb begin
      state_nxt    = state;
      is_rd_nxt    = is_rd;
      frm_nxt      = frm;
      tcnt_nxt     = tcnt;
      gcnt_nxt     = gcnt;
      rsp_nxt      = rsp;
      err_nxt      = err;
      wrt_nxt      = 1'b0;
      data_out_nxt = data_out;

      case (state)
         S_IDLE: begin
            if (cmd_vld) begin
               is_rd_nxt    = cmd_rd;
               frm_nxt      = 1'b0;
               err_nxt      = 1'b0;
               tcnt_nxt     = '0;
               wrt_nxt      = 1'b1;
               data_out_nxt = cmd;
               state_nxt    = S_LAUNCH;
            end
         end
         // tcnt counts cycles since the wrt strobe, so it is zero during LAUNCH
         S_LAUNCH: begin
            tcnt_nxt  = tcnt + TW'(1);
            state_nxt = S_WAIT_LOW;
         end
         S_WAIT_LOW: begin
            if (tcnt == T_LAST) begin
               err_nxt   = 1'b1;
               state_nxt = S_DONE;
            end else begin
               tcnt_nxt = tcnt + TW'(1);
               if (!done) state_nxt = S_WAIT_HIGH;
            end
         end
         // Completion takes priority over a timeout expiring on the same cycle
         S_WAIT_HIGH: begin
            if (done) begin
               if (frm) rsp_nxt = data_in;
               gcnt_nxt  = '0;
               state_nxt = S_GAP;
            end else if (tcnt == T_LAST) begin
               err_nxt   = 1'b1;
               state_nxt = S_DONE;
            end else begin
               tcnt_nxt = tcnt + TW'(1);
            end
         end
         S_GAP: begin
            if (gcnt == GAP_LAST) begin
               if (is_rd && !frm) begin
                  frm_nxt      = 1'b1;
                  tcnt_nxt     = '0;
                  wrt_nxt      = 1'b1;
                  data_out_nxt = DUMMY_WORD;
                  state_nxt    = S_LAUNCH;
               end else begin
                  state_nxt = S_DONE;
               end
            end else begin
               gcnt_nxt = gcnt + GW'(1);
            end
         end
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase

      busy_nxt    = (state_nxt != S_IDLE);
      rsp_vld_nxt = (state_nxt == S_DONE);
   end

endmodule

// File: tb/tb_spi_cmd_seq.sv
// Scoreboard bench for spi_cmd_seq with a behavioural SPI master model.
module tb_spi_cmd_seq;

   localparam int unsigned GAP_CYC     = 8;
   localparam int unsigned TIMEOUT_CYC = 2048;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_vld = 1'b0;
   logic        cmd_rd = 1'b0;
   logic [15:0] cmd = 16'h0000;
   logic        busy, rsp_vld, err, wrt;
   logic [15:0] rsp, data_out;
   logic        done = 1'b1;
   logic [15:0] data_in = 16'h0000;

   spi_cmd_seq #(.GAP_CYC(GAP_CYC), .TIMEOUT_CYC(TIMEOUT_CYC), .DUMMY_WORD(16'h0000)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_vld(cmd_vld), .cmd_rd(cmd_rd), .cmd(cmd),
      .busy(busy), .rsp_vld(rsp_vld), .rsp(rsp), .err(err), .wrt(wrt),
      .data_out(data_out), .done(done), .data_in(data_in)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   logic [15:0] exp_wrt_q[$];
   logic [16:0] exp_rsp_q[$];   // {err, rsp}
   int          sl_len_q[$];
   logic [15:0] sl_word_q[$];

   // master model and monitor state
   logic        m_act = 1'b0;
   int          m_cnt = 0;
   int          m_len = 0;
   logic [15:0] m_word = 16'h0000;
   int          wrt_cnt = 0;
   int          wrt_cyc = 0;
   int          done_cyc = 0;
   int          last_gap = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // One clock: sample on the falling edge, score DUT outputs, advance the master model
   task automatic tick();
      logic [16:0] e;
      @(negedge clk);
      if (!rst_n) begin
         m_act = 1'b0;
         done  = 1'b1;
      end else begin
         if (wrt) begin
            wrt_cnt++;
            last_gap = cyc - done_cyc;
            wrt_cyc  = cyc;
            if (exp_wrt_q.size() == 0) check_val("wrt_extra", 32'(data_out), 32'h1_0000);
            else check_val("wrt_data", 32'(data_out), 32'(exp_wrt_q.pop_front()));
         end
         if (rsp_vld) begin
            if (exp_rsp_q.size() == 0) check_val("rsp_extra", 32'(rsp), 32'h1_0000);
            else begin
               e = exp_rsp_q.pop_front();
               check_val("rsp_data", 32'(rsp), 32'(e[15:0]));
               check_val("rsp_err", 32'(err), 32'(e[16]));
            end
         end
         if (m_act) begin
            m_cnt++;
            if (m_cnt == 1) done = 1'b0;
            if (m_cnt == 1 + m_len) begin
               done     = 1'b1;
               data_in  = m_word;
               m_act    = 1'b0;
               done_cyc = cyc;
            end
         end else if (wrt && sl_len_q.size() > 0) begin
            m_act  = 1'b1;
            m_cnt  = 0;
            m_len  = sl_len_q.pop_front();
            m_word = sl_word_q.pop_front();
         end
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 6000) begin tick(); n++; end
      if (busy) check_val("idle_timeout", 32'(busy), 32'h0);
   endtask

   task automatic send(input logic rd, input logic [15:0] word);
      wait_idle();
      cmd_vld = 1'b1;
      cmd_rd  = rd;
      cmd     = word;
      tick();
      cmd_vld = 1'b0;
      check_val("busy_after_accept", 32'(busy), 32'h1);
   endtask

   task automatic wait_rsp();
      int n = 0;
      while (n < 6000) begin
         tick();
         if (rsp_vld) return;
         n++;
      end
      check_val("rsp_timeout", 32'h0, 32'h1);
   endtask

   task automatic push_frame(input int len, input logic [15:0] word);
      sl_len_q.push_back(len);
      sl_word_q.push_back(word);
   endtask

   initial begin
      int base;
      int n;

      repeat (3) tick();
      check_val("rst_busy", 32'(busy), 32'h0);
      check_val("rst_rsp_vld", 32'(rsp_vld), 32'h0);
      check_val("rst_rsp", 32'(rsp), 32'h0);
      check_val("rst_err", 32'(err), 32'h0);
      check_val("rst_wrt", 32'(wrt), 32'h0);
      check_val("rst_data_out", 32'(data_out), 32'h0);
      rst_n = 1'b1;
      repeat (2) tick();

      // write
      base = wrt_cnt;
      push_frame(540, 16'h5555);
      exp_wrt_q.push_back(16'hC0A5);
      exp_rsp_q.push_back({1'b0, 16'h0000});
      send(1'b0, 16'hC0A5);
      wait_rsp();
      check_val("wr_latency", 32'(cyc - done_cyc), 32'(GAP_CYC + 1));
      check_val("wr_strobes", 32'(wrt_cnt - base), 32'd1);

      // read with a rejected request while busy
      base = wrt_cnt;
      push_frame(540, 16'hDEAD);
      push_frame(540, 16'h1234);
      exp_wrt_q.push_back(16'h8300);
      exp_wrt_q.push_back(16'h0000);
      exp_rsp_q.push_back({1'b0, 16'h1234});
      send(1'b1, 16'h8300);
      repeat (20) tick();
      cmd_vld = 1'b1; cmd_rd = 1'b0; cmd = 16'hFFFF;
      tick();
      cmd_vld = 1'b0;
      wait_rsp();
      check_val("rd_strobes", 32'(wrt_cnt - base), 32'd2);
      check_val("rd_gap_min", 32'(last_gap >= int'(GAP_CYC) + 1), 32'h1);

      // accepted once idle; rsp held from the read
      push_frame(540, 16'h7777);
      exp_wrt_q.push_back(16'h5A5A);
      exp_rsp_q.push_back({1'b0, 16'h1234});
      send(1'b0, 16'h5A5A);
      wait_rsp();

      // timeout: master never starts
      exp_wrt_q.push_back(16'h1111);
      exp_rsp_q.push_back({1'b1, 16'h1234});
      send(1'b0, 16'h1111);
      wait_rsp();
      check_val("to_latency", 32'(cyc - wrt_cyc), 32'(TIMEOUT_CYC));
      tick();
      check_val("err_sticky", 32'(err), 32'h1);
      push_frame(540, 16'h0F0F);
      exp_wrt_q.push_back(16'h2222);
      exp_rsp_q.push_back({1'b0, 16'h1234});
      send(1'b0, 16'h2222);
      check_val("err_cleared", 32'(err), 32'h0);
      wait_rsp();

      // done rises on the last timeout cycle of frame 0
      base = wrt_cnt;
      push_frame(TIMEOUT_CYC - 2, 16'hDEAD);
      push_frame(540, 16'hABCD);
      exp_wrt_q.push_back(16'h8500);
      exp_wrt_q.push_back(16'h0000);
      exp_rsp_q.push_back({1'b0, 16'hABCD});
      send(1'b1, 16'h8500);
      wait_rsp();
      check_val("edge_strobes", 32'(wrt_cnt - base), 32'd2);

      // reset in the middle of the second frame of a read
      base = wrt_cnt;
      push_frame(540, 16'h1111);
      push_frame(540, 16'h2222);
      exp_wrt_q.push_back(16'h8400);
      exp_wrt_q.push_back(16'h0000);
      send(1'b1, 16'h8400);
      n = 0;
      while (wrt_cnt < base + 2 && n < 3000) begin tick(); n++; end
      check_val("rst_frame1_reached", 32'(wrt_cnt - base), 32'd2);
      repeat (100) tick();
      rst_n = 1'b0;
      #1;
      check_val("mid_rst_busy", 32'(busy), 32'h0);
      check_val("mid_rst_rsp", 32'(rsp), 32'h0);
      check_val("mid_rst_err", 32'(err), 32'h0);
      check_val("mid_rst_wrt", 32'(wrt), 32'h0);
      repeat (3) tick();
      check_val("mid_rst_rsp_vld", 32'(rsp_vld), 32'h0);
      rst_n = 1'b1;
      tick();
      push_frame(540, 16'h9999);
      exp_wrt_q.push_back(16'h3333);
      exp_rsp_q.push_back({1'b0, 16'h0000});
      send(1'b0, 16'h3333);
      wait_rsp();

      repeat (5) tick();
      check_val("wrt_q_drained", 32'(exp_wrt_q.size()), 32'h0);
      check_val("rsp_q_drained", 32'(exp_rsp_q.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
